// File: rtl/contador_estado.sv
// contador_estado: four-state countdown timer; each state shows Tn..1 as BCD, one value per DIV-cycle tick.
// Defining CONTADOR_PAUSA_EN makes the pausa input freeze counting; otherwise pausa is ignored.
module contador_estado #(
  parameter int DIV = 50000000,
  parameter int T0  = 30,
  parameter int T1  = 5,
  parameter int T2  = 20,
  parameter int T3  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iniciar,
  input  logic       pausa,
  output logic [1:0] estado_out,
  output logic [1:0] dez_out,
  output logic [3:0] unid_out,
  output logic       fim_estado
);

  localparam int PW = $clog2(DIV);

  // Durations are clamped to 1..39 so they always fit a 2-bit tens digit.
  function automatic logic [5:0] to_bcd(input int t);
    int c;
    c = (t < 1) ? 1 : ((t > 39) ? 39 : t);
    return {2'(c / 10), 4'(c % 10)};
  endfunction

  localparam logic [5:0] BCD0 = to_bcd(T0);
  localparam logic [5:0] BCD1 = to_bcd(T1);
  localparam logic [5:0] BCD2 = to_bcd(T2);
  localparam logic [5:0] BCD3 = to_bcd(T3);

  typedef enum logic {PARADO, CONTANDO} run_t;

  run_t          run_q, run_d;
  logic [PW-1:0] presc;
  logic          hold;
  logic          tick;
  logic          ultimo;
  logic [5:0]    carga;

`ifdef CONTADOR_PAUSA_EN
  assign hold = pausa;
`else
  logic unused_pausa;
  assign unused_pausa = pausa;
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= PARADO;
    else        run_q <= run_d;
  end

  always_comb begin
    run_d = run_q;
    tick  = 1'b0;
    if (run_q == PARADO) begin
      if (iniciar) run_d = CONTANDO;
    end else if (!hold && (presc == PW'(DIV - 1))) begin
      tick = 1'b1;
    end
  end

  assign ultimo = (dez_out == 2'd0) && (unid_out == 4'd1);

  // Value loaded on leaving the current state, i.e. the next state's duration.
  always_comb begin
    carga = BCD0;
    case (estado_out)
      2'd0:    carga = BCD1;
      2'd1:    carga = BCD2;
      2'd2:    carga = BCD3;
      default: carga = BCD0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc                 <= '0;
      estado_out            <= 2'd0;
      {dez_out, unid_out}   <= BCD0;
      fim_estado            <= 1'b0;
    end else begin
      fim_estado <= 1'b0;
      if (run_q == CONTANDO && !hold) begin
        presc <= tick ? '0 : presc + 1'b1;
      end
      if (tick) begin
        if (ultimo) begin
          estado_out          <= estado_out + 2'd1;
          {dez_out, unid_out} <= carga;
          fim_estado          <= 1'b1;
        end else if (unid_out == 4'd0) begin
          unid_out <= 4'd9;
          dez_out  <= dez_out - 2'd1;
        end else begin
          unid_out <= unid_out - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_contador_estado.sv
// Bench for contador_estado: integer-valued reference model compared every cycle,
// plus hand-computed checkpoints on a small configuration and a clamping instance.
module tb_contador_estado;

  localparam int DIV = 4;
  localparam int T0 = 3, T1 = 2, T2 = 12, T3 = 1;
  localparam int TD [4] = '{T0, T1, T2, T3};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iniciar;
  logic       pausa;
  logic       ini2;
  logic [1:0] estado_out, dez_out, est2, dez2;
  logic [3:0] unid_out, unid2;
  logic       fim_estado, fim2;

  int n_chk  = 0;
  int n_fail = 0;
  int t      = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  contador_estado #(.DIV(DIV), .T0(T0), .T1(T1), .T2(T2), .T3(T3)) dut (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .pausa(pausa),
    .estado_out(estado_out), .dez_out(dez_out), .unid_out(unid_out), .fim_estado(fim_estado)
  );

  // Clamping instance: 45 -> 39 and 0 -> 1.
  contador_estado #(.DIV(2), .T0(45), .T1(0), .T2(7), .T3(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .iniciar(ini2), .pausa(1'b0),
    .estado_out(est2), .dez_out(dez2), .unid_out(unid2), .fim_estado(fim2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_to(input int e);
    while (t < e) begin
      @(negedge clk);
      t++;
    end
  endtask

  // Reference model: remaining ticks kept as a plain integer.
  int   m_st = 0, m_val = T0, m_pre = 0;
  bit   m_run = 1'b0, m_fim = 1'b0;
  logic m_hold;
`ifdef CONTADOR_PAUSA_EN
  assign m_hold = pausa;
`else
  assign m_hold = 1'b0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_val = TD[0]; m_pre = 0; m_run = 1'b0; m_fim = 1'b0;
    end else begin
      m_fim = 1'b0;
      if (!m_run) begin
        m_run = iniciar;
      end else if (!m_hold) begin
        if (m_pre == DIV - 1) begin
          m_pre = 0;
          if (m_val == 1) begin
            m_st  = (m_st + 1) % 4;
            m_val = TD[m_st];
            m_fim = 1'b1;
          end else begin
            m_val--;
          end
        end else begin
          m_pre++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      chk("cyc_estado", estado_out, m_st);
      chk("cyc_dez", dez_out, m_val / 10);
      chk("cyc_unid", unid_out, m_val % 10);
      chk("cyc_fim", fim_estado, m_fim);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; iniciar = 1'b0; pausa = 1'b0; ini2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_estado", estado_out, 0);
    chk("rst_dez", dez_out, 0);
    chk("rst_unid", unid_out, 3);
    chk("rst_fim", fim_estado, 0);
    chk("rst2_dez", dez2, 3);
    chk("rst2_unid", unid2, 9);
    chk_on = 1'b1;
    rst_n  = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_estado", estado_out, 0);
    chk("idle_unid", unid_out, 3);

    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    t = 0;
    wait_to(3);  chk("t3_unid", unid_out, 3);
    wait_to(4);  chk("t4_unid", unid_out, 2);
    wait_to(8);  chk("t8_unid", unid_out, 1);
    wait_to(12); chk("t12_estado", estado_out, 1); chk("t12_unid", unid_out, 2); chk("t12_fim", fim_estado, 1);
    wait_to(13); chk("t13_fim", fim_estado, 0);
    wait_to(20); chk("t20_estado", estado_out, 2); chk("t20_dez", dez_out, 1); chk("t20_unid", unid_out, 2);
    wait_to(24); chk("t24_unid", unid_out, 1);
    wait_to(28); chk("t28_dez", dez_out, 1); chk("t28_unid", unid_out, 0);
    wait_to(32); chk("t32_dez", dez_out, 0); chk("t32_unid", unid_out, 9);
    wait_to(40); iniciar = 1'b1;
    wait_to(41); iniciar = 1'b0;
    wait_to(68); chk("t68_estado", estado_out, 3); chk("t68_unid", unid_out, 1);
    wait_to(72); chk("t72_estado", estado_out, 0); chk("t72_unid", unid_out, 3); chk("t72_fim", fim_estado, 1);
    wait_to(73); chk("t73_fim", fim_estado, 0);

    wait_to(74); pausa = 1'b1;
`ifdef CONTADOR_PAUSA_EN
    wait_to(80); chk("pause_hold_unid", unid_out, 3);
    wait_to(84); pausa = 1'b0;
    wait_to(85); chk("pause_t85_unid", unid_out, 3);
    wait_to(86); chk("pause_t86_unid", unid_out, 2); chk("pause_t86_estado", estado_out, 0);
`else
    wait_to(76); chk("nopause_t76_unid", unid_out, 2);
    wait_to(84); pausa = 1'b0;
    wait_to(86); chk("nopause_t86_estado", estado_out, 1); chk("nopause_t86_unid", unid_out, 2);
`endif

    begin
      int n = 0;
      while (estado_out != 2'd2 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("reach_st2_in_time", (n < 200), 1);
    end
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_estado", estado_out, 0);
    chk("arst_dez", dez_out, 0);
    chk("arst_unid", unid_out, 3);
    chk("arst_fim", fim_estado, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_estado", estado_out, 0);
    chk("post_rst_unid", unid_out, 3);

    ini2 = 1'b1;
    @(negedge clk);
    ini2 = 1'b0;
    t = 0;
    wait_to(2);  chk("c2_t2_dez", dez2, 3); chk("c2_t2_unid", unid2, 8);
    wait_to(20); chk("c2_t20_dez", dez2, 2); chk("c2_t20_unid", unid2, 9);
    wait_to(76); chk("c2_t76_estado", est2, 0); chk("c2_t76_dez", dez2, 0); chk("c2_t76_unid", unid2, 1);
    wait_to(78); chk("c2_t78_estado", est2, 1); chk("c2_t78_unid", unid2, 1); chk("c2_t78_fim", fim2, 1);
    wait_to(80); chk("c2_t80_estado", est2, 2); chk("c2_t80_unid", unid2, 7); chk("c2_t80_fim", fim2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/contador_estado.md
CONTADOR_ESTADO -- requirements
Module: contador_estado

Interface
REQ-001 SHALL have parameter DIV, default 50000000: clock cycles per count tick (>=2).
REQ-002 SHALL have parameters T0, T1, T2, T3, defaults 30, 5, 20, 10: duration in ticks of estado 00, 01, 10, 11.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port iniciar, input, 1: start request, sampled per clk.
REQ-006 SHALL have port pausa, input, 1: hold counting; functional only per REQ-025.
REQ-007 SHALL have port estado_out, output, 2: current state code, feeds the estado decoder input.
REQ-008 SHALL have port dez_out, output, 2: BCD tens digit 0-3, feeds the 2-bit digit decoder.
REQ-009 SHALL have port unid_out, output, 4: BCD units digit 0-9, feeds the 4-bit digit decoder.
REQ-010 SHALL have port fim_estado, output, 1: one-cycle pulse on every state change.

Function
REQ-011 SHALL hold an internal run flag: parado, or contando.
- After reset the flag is parado.
- iniciar=1 in parado sets contando on the next edge.
- iniciar in contando is ignored.
REQ-012 SHALL run a prescaler 0..DIV-1 only while contando.
- tick = one-cycle internal strobe when prescaler == DIV-1.
- Prescaler wraps to 0 on tick.
- Prescaler is 0 on entering contando.
REQ-013 SHALL clamp each Tn at elaboration: 0 becomes 1, values >39 become 39.
REQ-014 SHALL, on tick with value (dez,unid) != 01:
- if unid=0: unid<=9 and dez<=dez-1;
- otherwise: unid<=unid-1.
REQ-015 SHALL, on tick with value == 01:
- estado<=estado+1, wrapping 11->00;
- load the new state's Tn as BCD;
- assert fim_estado for that one cycle.
REQ-016 SHALL therefore display values Tn..1 for one tick each, giving exactly Tn ticks per state; value 00 is never shown.
REQ-017 SHALL keep unid_out within 0-9 and dez_out within 0-3 at all times.
REQ-018 SHALL drive all outputs from registers; no combinational path from inputs to outputs.
REQ-019 SHALL keep fim_estado=0 except in the cycle given by REQ-015.
REQ-020 SHALL, while parado, hold estado_out, dez_out and unid_out constant.

Reset
REQ-021 SHALL, on rst_n=0 and without waiting for a clock edge, set:
- estado_out=00, (dez_out,unid_out)=BCD(T0), fim_estado=0;
- prescaler=0, run flag=parado.
REQ-022 SHALL, when reset is asserted mid-count, discard all progress; counting resumes only after a fresh iniciar.
REQ-023 SHALL sample iniciar no earlier than the first clk edge after rst_n deasserts.

Configuration
REQ-024 SHALL provide feature macro CONTADOR_PAUSA_EN.
REQ-025 SHALL behave as follows when CONTADOR_PAUSA_EN is defined:
- pausa=1 in contando freezes the prescaler, the value and estado, and suppresses tick and fim_estado;
- counting resumes from the held prescaler value when pausa returns to 0;
- if iniciar and pausa are both 1 in parado, pausa wins: the block enters contando but does not count until pausa=0.
REQ-026 SHALL ignore pausa entirely when CONTADOR_PAUSA_EN is undefined; the port remains present.

Verification (DIV=4, T0=3, T1=2, T2=12, T3=1)
REQ-027 Reset: rst_n=0 -> estado_out=00, dez_out=0, unid_out=3, fim_estado=0; with no iniciar, outputs stay constant for 100 cycles.
REQ-028 Start and transition: pulse iniciar -> value 2 after 4 cycles, 1 after 8; after 12 cycles estado_out=01, value 2, fim_estado=1 for exactly one cycle.
REQ-029 BCD borrow: in estado 10 the value sequence is 12, 11, 10, 09 (dez 1/unid 0 -> dez 0/unid 9), continuing down to 1, then estado 11 with value 1.
REQ-030 Wrap: estado 11 lasts one tick (4 cycles), then estado_out=00, value 3, fim_estado pulse.
REQ-031 Pause with CONTADOR_PAUSA_EN: pausa=1 for 10 cycles at prescaler=2 -> outputs frozen; the next tick arrives 2 cycles after release. Without the macro, the same stimulus has no effect on timing.
REQ-032 Async reset: drop rst_n between clk edges mid-state 10 -> outputs reach reset values before the next edge; with iniciar=0 afterwards, the block stays parado.
